fir_sum: RTL

FIR_SUM -- requirements
Module: fir_sum

---
 rtl/fir_sum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sum.sv
// fir_sum -- sequential adder for polyphase FIR bank outputs.
//
// On each start strobe, the module takes a copy of all M bank outputs. It adds
// them into a wide accumulator, one bank per clock. It then scales the sum by
// SHIFT bits, saturates it to OUTPUT_WIDTH and presents the result together
// with a one-cycle valid pulse.
//
// Build option:
//   FIR_SUM_ROUND_EN  defined   -> round half to even before the shift
//                     undefined -> truncate (floor); latency is the same
//
// Ports:
//   clk              rising-edge clock for all logic
//   rst              asynchronous, active-high reset
//   clk_2mhz_pos_en  one-cycle start strobe (one per decimated sample)
//   din              M packed signed banks, bank k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   dout             signed, scaled and saturated sum; holds until the next valid
//   valid            one-cycle pulse that qualifies dout and ovf
//   ovf              saturation flag, qualified by valid
//   busy             high while a sum is in progress (state != IDLE)
//   dropped          one-cycle pulse when a start arrives while busy
module fir_sum #(
  parameter int M            = 20,
  parameter int INPUT_WIDTH  = 35,
  parameter int SHIFT        = 26,
  parameter int OUTPUT_WIDTH = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_2mhz_pos_en,
  input  logic [M*INPUT_WIDTH-1:0]       din,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           valid,
  output logic                           ovf,
  output logic                           busy,
  output logic                           dropped
);

  // A sum of M values needs $clog2(M) growth bits, so the accumulator cannot wrap.
  localparam int ACC_WIDTH = INPUT_WIDTH + $clog2(M);
  localparam int IDX_WIDTH = (M > 1) ? $clog2(M) : 1;
  // The scaled value keeps the extra rounding headroom bit.
  localparam int Q_WIDTH   = ACC_WIDTH + 1 - SHIFT;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(M - 1);

  localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [1:0]                     state_reg;
  logic signed [ACC_WIDTH-1:0]    acc_reg;
  logic [IDX_WIDTH-1:0]           idx_reg;
  logic signed [OUTPUT_WIDTH-1:0] dout_reg;
  logic                           valid_reg;
  logic                           ovf_reg;
  logic                           dropped_reg;

  logic                           start_accept;
  logic signed [INPUT_WIDTH-1:0]  din_bank [M];
  logic signed [INPUT_WIDTH-1:0]  snap_reg [M];
  logic signed [INPUT_WIDTH-1:0]  snap_cur;
  logic signed [ACC_WIDTH-1:0]    snap_ext;

  logic signed [ACC_WIDTH:0]      acc_ext;
  logic signed [ACC_WIDTH:0]      rnd_sum;
  logic signed [Q_WIDTH-1:0]      q;
  logic signed [OUTPUT_WIDTH-1:0] q_sat;
  logic                           sat_hit;

  assign start_accept = clk_2mhz_pos_en && (state_reg == IDLE);

  // Unpack the flat bus into one signed word per bank.
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_unpack
      assign din_bank[gi] = din[gi*INPUT_WIDTH +: INPUT_WIDTH];
    end
  endgenerate

  // The snapshot is taken only on an accepted start. din may change freely
  // while the sum runs. The snapshot needs no reset because the start edge
  // always writes it before it is read.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      snap_reg <= din_bank;
    end
  end

  assign snap_cur = snap_reg[idx_reg];
  assign snap_ext = {{(ACC_WIDTH-INPUT_WIDTH){snap_cur[INPUT_WIDTH-1]}}, snap_cur};

  // Scaling. The slice [ACC_WIDTH:SHIFT] of a signed value is its arithmetic
  // right shift by SHIFT.
  assign acc_ext = {acc_reg[ACC_WIDTH-1], acc_reg};

`ifdef FIR_SUM_ROUND_EN
  // Round half to even: add 2^(SHIFT-1)-1, plus the LSB that survives the shift.
  // An exact tie therefore moves up only when the kept value is odd.
  localparam logic [ACC_WIDTH:0] HALF_M1 =
    {{(ACC_WIDTH+2-SHIFT){1'b0}}, {(SHIFT-1){1'b1}}};
  assign rnd_sum = acc_ext + $signed(HALF_M1)
                   + $signed({{ACC_WIDTH{1'b0}}, acc_reg[SHIFT]});
`else
  // Truncation: the plain arithmetic shift rounds toward minus infinity.
  assign rnd_sum = acc_ext;
`endif

  assign q = rnd_sum[ACC_WIDTH:SHIFT];

  // Saturation. q fits the output only when its bits from the output sign bit
  // upward are all equal.
  generate
    if (Q_WIDTH > OUTPUT_WIDTH) begin : g_sat
      logic [Q_WIDTH-OUTPUT_WIDTH:0] q_top;
      assign q_top   = q[Q_WIDTH-1:OUTPUT_WIDTH-1];
      assign sat_hit = !((&q_top) || !(|q_top));
      assign q_sat   = sat_hit ? (q[Q_WIDTH-1] ? OUT_MIN : OUT_MAX)
                               : q[OUTPUT_WIDTH-1:0];
    end else begin : g_nosat
      assign sat_hit = 1'b0;
      assign q_sat   = OUTPUT_WIDTH'(q);
    end
  endgenerate

  // Control FSM. IDLE -> ACC takes M cycles, one bank per cycle.
  // ACC -> ROUND takes one cycle, then the FSM returns to IDLE.
  // A start is accepted only in IDLE. A start seen on the ROUND edge is
  // therefore dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      idx_reg     <= '0;
      dout_reg    <= '0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      dropped_reg <= clk_2mhz_pos_en && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (clk_2mhz_pos_en) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ACC;
          end
        end
        ACC: begin
          acc_reg <= acc_reg + snap_ext;
          if (idx_reg == LAST_IDX) begin
            idx_reg   <= '0;
            state_reg <= ROUND;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ROUND: begin
          dout_reg  <= q_sat;
          ovf_reg   <= sat_hit;
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dout    = dout_reg;
  assign valid   = valid_reg;
  assign ovf     = ovf_reg;
  assign dropped = dropped_reg;
  assign busy    = (state_reg != IDLE);

endmodule
